// File: rtl/y_ctrl_fsm_if.sv
`default_nettype none
// ------------------------------------------------------------------
// y_ctrl_fsm_if : datapath bundle between y_ctrl_fsm and yIF/yID/yEX/yDM/yWB
// Revision 1.0
// ------------------------------------------------------------------
interface y_ctrl_fsm_if;
  logic        run;
  logic [31:0] ins;
  logic        zero;
  logic [31:0] PCp4;
  logic [31:0] branch;
  logic [31:0] jTarget;
  logic [31:0] PCin;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  op;
  logic        MemRead;
  logic        MemWrite;
  logic        Mem2Reg;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    input  run, ins, zero, PCp4, branch, jTarget,
    output PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, illegal, state, retired
  );

  modport slave (
    output run, ins, zero, PCp4, branch, jTarget,
    input  PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, illegal, state, retired
  );
endinterface
`default_nettype wire

// File: rtl/y_ctrl_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// y_ctrl_fsm : multi-cycle control unit and PC register
// Revision 1.0
// ------------------------------------------------------------------
module y_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h28
) (
  input  wire logic    clk,
  input  wire logic    reset,
  y_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LW  = 7'h03;
  localparam logic [6:0] OPC_SW  = 7'h23;
  localparam logic [6:0] OPC_BEQ = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] ir;
  logic [31:0] nxt_ir;
  logic [31:0] pc;
  logic [31:0] nxt_pc;
  logic [31:0] ret_cnt;
  logic [31:0] nxt_ret_cnt;

  logic        alu_src;
  logic [2:0]  alu_op;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        illegal_q;

  logic        dec_alu_src;
  logic [2:0]  dec_op;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_mem_to_reg;
  logic        dec_illegal;

  function automatic logic is_supported(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL: is_supported = 1'b1;
      default:                                        is_supported = 1'b0;
    endcase
  endfunction

  // Shared R/I funct3 map; only R-type honours ir[30] as the sub selector.
  function automatic logic [2:0] funct_op(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  funct_op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  funct_op = ALU_AND;
      3'b110:  funct_op = ALU_OR;
      3'b010:  funct_op = ALU_SLT;
      default: funct_op = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    nxt_state   = cur_state;
    nxt_ir      = ir;
    nxt_pc      = pc;
    nxt_ret_cnt = ret_cnt;
    case (cur_state)
      FETCH: begin
        if (bus.run) begin
          nxt_ir    = bus.ins;
          nxt_state = DECODE;
        end
      end
      DECODE: begin
        if (is_supported(ir[6:0])) begin
          nxt_state = EXEC;
        end else begin
          nxt_pc      = bus.PCp4;
          nxt_ret_cnt = ret_cnt + 32'd1;
          nxt_state   = FETCH;
        end
      end
      EXEC: begin
        case (ir[6:0])
          OPC_LW, OPC_SW: nxt_state = MEM;
          OPC_BEQ: begin
            nxt_pc      = bus.zero ? bus.branch : bus.PCp4;
            nxt_ret_cnt = ret_cnt + 32'd1;
            nxt_state   = FETCH;
          end
          default: nxt_state = WB;
        endcase
      end
      MEM: begin
        if (ir[6:0] == OPC_LW) begin
          nxt_state = WB;
        end else begin
          nxt_pc      = bus.PCp4;
          nxt_ret_cnt = ret_cnt + 32'd1;
          nxt_state   = FETCH;
        end
      end
      WB: begin
        nxt_pc      = (ir[6:0] == OPC_JAL) ? bus.jTarget : bus.PCp4;
        nxt_ret_cnt = ret_cnt + 32'd1;
        nxt_state   = FETCH;
      end
      default: nxt_state = FETCH;
    endcase
  end

  // Decode the controls for the state being entered so they appear registered
  // in the same cycle as that state; ALUSrc/op stay valid through MEM and WB.
  always_comb begin
    dec_alu_src    = 1'b0;
    dec_op         = ALU_ADD;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_illegal    = 1'b0;
    case (nxt_state)
      DECODE: dec_illegal = !is_supported(nxt_ir[6:0]);
      EXEC, MEM, WB: begin
        case (nxt_ir[6:0])
          OPC_R:   dec_op = funct_op(nxt_ir[14:12], nxt_ir[30]);
          OPC_I: begin
            dec_alu_src = 1'b1;
            dec_op      = funct_op(nxt_ir[14:12], 1'b0);
          end
          OPC_BEQ: dec_op = ALU_SUB;
          default: dec_alu_src = 1'b1;
        endcase
        dec_mem_read   = (nxt_state == MEM) && (nxt_ir[6:0] == OPC_LW);
        dec_mem_write  = (nxt_state == MEM) && (nxt_ir[6:0] == OPC_SW);
        dec_reg_write  = (nxt_state == WB);
        dec_mem_to_reg = (nxt_state == WB) && (nxt_ir[6:0] == OPC_LW);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= FETCH;
      ir         <= '0;
      pc         <= RESET_PC;
      ret_cnt    <= '0;
      alu_src    <= 1'b0;
      alu_op     <= ALU_ADD;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      ir         <= nxt_ir;
      pc         <= nxt_pc;
      ret_cnt    <= nxt_ret_cnt;
      alu_src    <= dec_alu_src;
      alu_op     <= dec_op;
      reg_write  <= dec_reg_write;
      mem_read   <= dec_mem_read;
      mem_write  <= dec_mem_write;
      mem_to_reg <= dec_mem_to_reg;
      illegal_q  <= dec_illegal;
    end
  end

  assign bus.PCin     = pc;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrc   = alu_src;
  assign bus.op       = alu_op;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.Mem2Reg  = mem_to_reg;
  assign bus.illegal  = illegal_q;
  assign bus.state    = cur_state;
  assign bus.retired  = ret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_y_ctrl_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_y_ctrl_fsm : randomized self-checking bench for y_ctrl_fsm
// Revision 1.0
// ------------------------------------------------------------------
module tb_y_ctrl_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] m_pc;
  logic [31:0] m_ret;

  y_ctrl_fsm_if bus ();

  y_ctrl_fsm #(.RESET_PC(32'h28)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // yIF stand-in: PC+4 with natural 32-bit wrap
  assign bus.PCp4 = bus.PCin + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic supported(input logic [6:0] opc);
    return (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h03) ||
           (opc == 7'h23) || (opc == 7'h63) || (opc == 7'h6F);
  endfunction

  function automatic logic [2:0] ref_op(input logic [31:0] i);
    logic [2:0] r;
    r = 3'b010;
    if (i[6:0] == 7'h63) r = 3'b110;
    else if (i[6:0] == 7'h33 || i[6:0] == 7'h13) begin
      case (i[14:12])
        3'b000:  r = (i[6:0] == 7'h33 && i[30]) ? 3'b110 : 3'b010;
        3'b111:  r = 3'b000;
        3'b110:  r = 3'b001;
        3'b010:  r = 3'b111;
        default: r = 3'b010;
      endcase
    end
    return r;
  endfunction

  function automatic logic [4:0] strobes();
    return {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Mem2Reg, bus.illegal};
  endfunction

  // Walks one instruction from FETCH back to FETCH, checking every cycle.
  task automatic run_instr(input logic [31:0] i, input logic z,
                           input logic [31:0] br, input logic [31:0] jt);
    logic       lw, sw, beq, jal, bad;
    int         n;
    logic [2:0] es;
    logic [4:0] estr;
    logic [3:0] eexec;
    lw  = (i[6:0] == 7'h03);
    sw  = (i[6:0] == 7'h23);
    beq = (i[6:0] == 7'h63);
    jal = (i[6:0] == 7'h6F);
    bad = !supported(i[6:0]);
    n   = bad ? 2 : beq ? 3 : lw ? 5 : 4;
    bus.ins = i; bus.zero = z; bus.branch = br; bus.jTarget = jt; bus.run = 1'b1;
    for (int k = 0; k < n; k++) begin
      es   = (k < 3) ? 3'(k) : ((k == 3 && (lw || sw)) ? 3'd3 : 3'd4);
      estr = {es == 3'd4, es == 3'd3 && lw, es == 3'd3 && sw, es == 3'd4 && lw, es == 3'd1 && bad};
      checks++;
      if (bus.state !== es) begin
        errors++; $display("FAIL state ins=%h step=%0d got=%0d exp=%0d", i, k, bus.state, es);
      end
      checks++;
      if (strobes() !== estr) begin
        errors++; $display("FAIL strobes ins=%h step=%0d got=%b exp=%b", i, k, strobes(), estr);
      end
      checks++;
      if (bus.PCin !== m_pc) begin
        errors++; $display("FAIL pc_hold ins=%h step=%0d got=%h exp=%h", i, k, bus.PCin, m_pc);
      end
      if (es == 3'd2) begin
        eexec = {(i[6:0] != 7'h33 && i[6:0] != 7'h63), ref_op(i)};
        checks++;
        if ({bus.ALUSrc, bus.op} !== eexec) begin
          errors++; $display("FAIL exec_ctl ins=%h got=%b exp=%b", i, {bus.ALUSrc, bus.op}, eexec);
        end
      end
      @(negedge clk);
      bus.run = 1'b0;
      bus.ins = $urandom;
    end
    m_pc  = bad ? m_pc + 32'd4 : beq ? (z ? br : m_pc + 32'd4) : jal ? jt : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    checks++;
    if (bus.state !== 3'd0 || bus.PCin !== m_pc) begin
      errors++; $display("FAIL end_pc ins=%h got=%0d/%h exp=0/%h", i, bus.state, bus.PCin, m_pc);
    end
    checks++;
    if (bus.retired !== m_ret) begin
      errors++; $display("FAIL retired ins=%h got=%0d exp=%0d", i, bus.retired, m_ret);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.run = 1'b1;
    m_pc = 32'h28; m_ret = 0;
    checks++;
    if (bus.PCin !== 32'h28 || bus.state !== 3'd0 || bus.retired !== 32'd0) begin
      errors++; $display("FAIL reset_regs got pc=%h st=%0d ret=%0d exp pc=28 st=0 ret=0",
                         bus.PCin, bus.state, bus.retired);
    end
    checks++;
    if ({strobes(), bus.ALUSrc, bus.op} !== 9'b00000_0_010) begin
      errors++; $display("FAIL reset_ctl got=%b exp=000000010", {strobes(), bus.ALUSrc, bus.op});
    end
  endtask

  task automatic test_r_add();
    run_instr(32'h002081B3, 1'b0, 32'h0, 32'h0);
    checks++;
    if (bus.PCin !== 32'h2C) begin
      errors++; $display("FAIL r_add_pc got=%h exp=0000002c", bus.PCin);
    end
  endtask

  task automatic test_load_store();
    run_instr(32'h0000A183, 1'b0, 32'h0, 32'h0);
    run_instr(32'h0030A223, 1'b1, 32'h0, 32'h0);
  endtask

  task automatic test_branch();
    run_instr(32'h00208463, 1'b1, 32'h40, 32'h0);
    checks++;
    if (bus.PCin !== 32'h40) begin
      errors++; $display("FAIL beq_taken got=%h exp=00000040", bus.PCin);
    end
    run_instr(32'h00208463, 1'b0, 32'h80, 32'h0);
    run_instr(32'h00208463, 1'b1, 32'hFFFF_FFFC, 32'h0);
    run_instr(32'h002081B3, 1'b0, 32'h0, 32'h0);
    checks++;
    if (bus.PCin !== 32'h0) begin
      errors++; $display("FAIL pc_wrap got=%h exp=00000000", bus.PCin);
    end
  endtask

  task automatic test_illegal_jal();
    run_instr(32'h0000007F, 1'b1, 32'h0, 32'h0);
    run_instr(32'h0000006F, 1'b0, 32'h0, 32'h100);
    checks++;
    if (bus.PCin !== 32'h100) begin
      errors++; $display("FAIL jal_pc got=%h exp=00000100", bus.PCin);
    end
  endtask

  task automatic test_reset_abort();
    bool_found: begin end
    bus.ins = 32'h0030A223; bus.run = 1'b1;
    for (int k = 0; k < 8 && bus.state !== 3'd3; k++) begin
      @(negedge clk);
      bus.run = 1'b0;
    end
    checks++;
    if (bus.state !== 3'd3 || bus.MemWrite !== 1'b1) begin
      errors++; $display("FAIL sw_mem_reach got st=%0d mw=%b exp st=3 mw=1", bus.state, bus.MemWrite);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_pc = 32'h28; m_ret = 0;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.PCin !== 32'h28 || bus.state !== 3'd0 || bus.retired !== 32'd0) begin
      errors++; $display("FAIL reset_abort got mw=%b pc=%h st=%0d ret=%0d exp mw=0 pc=28 st=0 ret=0",
                         bus.MemWrite, bus.PCin, bus.state, bus.retired);
    end
  endtask

  task automatic test_run_hold();
    bus.run = 1'b0;
    bus.ins = 32'h002081B3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 3'd0 || bus.PCin !== m_pc || strobes() !== 5'b0) begin
        errors++; $display("FAIL run_hold cyc=%0d got st=%0d pc=%h exp st=0 pc=%h",
                           k, bus.state, bus.PCin, m_pc);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  bad_opc [7];
    logic [31:0] i;
    bad_opc = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h0F, 7'h73, 7'h00};
    for (int t = 0; t < 60; t++) begin
      i = $urandom;
      case ($urandom_range(0, 7))
        0, 7: i[6:0] = 7'h33;
        1:    i[6:0] = 7'h13;
        2:    i[6:0] = 7'h03;
        3:    i[6:0] = 7'h23;
        4:    i[6:0] = 7'h63;
        5:    i[6:0] = 7'h6F;
        default: i[6:0] = bad_opc[$urandom_range(0, 6)];
      endcase
      run_instr(i, 1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) test_run_hold();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.run = 1'b0; bus.ins = '0; bus.zero = 1'b0; bus.branch = '0; bus.jTarget = '0;
    m_pc = 32'h28; m_ret = 0;
    @(negedge clk);
    test_reset();
    test_r_add();
    test_load_store();
    test_branch();
    test_illegal_jal();
    test_reset_abort();
    test_run_hold();
    test_random();
    test_r_add_after_random: begin end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
